// File: rtl/cpu7_csr_timers_pkg.sv
// Shared register layout and helpers for the multi-channel CSR timer unit.
package cpu7_csr_timers_pkg;

  localparam int LCSR_BIT = 14;
  localparam logic [LCSR_BIT-1:0] LTIMER_BASE_ADDR = 14'h41;

  // TCFG field positions
  localparam int LTCFG_EN       = 0;
  localparam int LTCFG_PERIODIC = 1;
  localparam int LTCFG_INITVAL  = 2;

  // Per-channel register offsets from the channel's TCFG address
  localparam int LTCFG_OFF  = 0;
  localparam int LTVAL_OFF  = 1;
  localparam int LTICLR_OFF = 3;
  localparam int LTICLR_CLR = 0;

  // Channel stride; PRESC sits right after the last channel
  localparam int LPRESC_STRIDE = 4;

  function automatic logic [31:0] masked_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/cpu7_csr_timer_chan.sv
// One countdown timer channel: TCFG fields, counter, one-shot done flag and
// the registered interrupt pending bit.
module cpu7_csr_timer_chan
  import cpu7_csr_timers_pkg::*;
#(
  parameter int TIMER_BIT = 30
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic        cfg_wen,
  input  logic        ticlr_wen,
  input  logic [31:0] wdata,
  input  logic [31:0] mask,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        pending
);

  logic                 r_en;
  logic                 r_periodic;
  logic                 r_done;
  logic                 r_pending;
  logic [TIMER_BIT-1:0] r_initval;
  logic [TIMER_BIT-1:0] r_count;

  logic [31:0] w_cfg_new;
  logic        w_active;
  logic        w_expire;
  logic        w_clear;

  assign tcfg    = 32'({r_initval, r_periodic, r_en});
  assign tval    = 32'(r_count);
  assign pending = r_pending;

  assign w_cfg_new = masked_merge(tcfg, wdata, mask);
  // A config write on a tick cycle takes priority, so the tick is dropped.
  assign w_active  = tick & r_en & ~r_done & ~cfg_wen;
  assign w_expire  = w_active & (r_count == '0);
  assign w_clear   = ticlr_wen & wdata[LTICLR_CLR] & mask[LTICLR_CLR];

  generate
    if (TIMER_BIT < 30) begin : g_unused_cfg
      logic w_unused_cfg_bits;
      assign w_unused_cfg_bits = ^w_cfg_new[31:TIMER_BIT+2];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_initval  <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
    end else if (cfg_wen) begin
      r_en       <= w_cfg_new[LTCFG_EN];
      r_periodic <= w_cfg_new[LTCFG_PERIODIC];
      r_initval  <= w_cfg_new[LTCFG_INITVAL +: TIMER_BIT];
      r_count    <= w_cfg_new[LTCFG_INITVAL +: TIMER_BIT];
      r_done     <= 1'b0;
    end else if (w_active) begin
      if (r_count != '0) begin
        r_count <= r_count - TIMER_BIT'(1);
      end else if (r_periodic) begin
        r_count <= r_initval;
      end else begin
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
    end else if (w_clear) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu7_csr_timers.sv
// Multi-channel CSR timer unit: shared prescaler, address decode, read mux
// and NTIMER independent countdown channels.
module cpu7_csr_timers
  import cpu7_csr_timers_pkg::*;
#(
  parameter int                  NTIMER       = 2,
  parameter int                  TIMER_BIT    = 30,
  parameter int                  PRESCALE_BIT = 8,
  parameter logic [LCSR_BIT-1:0] BASE_ADDR    = LTIMER_BASE_ADDR
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [LCSR_BIT-1:0] csr_raddr,
  output logic [31:0]         csr_rdata,
  input  logic [LCSR_BIT-1:0] csr_waddr,
  input  logic [31:0]         csr_wdata,
  input  logic [31:0]         csr_mask,
  input  logic                csr_wen,
  output logic [NTIMER-1:0]   timer_intr,
  output logic                timer_intr_any
);

  localparam logic [LCSR_BIT-1:0] PRESC_ADDR =
    BASE_ADDR + LCSR_BIT'(LPRESC_STRIDE * NTIMER);

  logic [PRESCALE_BIT-1:0] r_presc;
  logic [PRESCALE_BIT-1:0] r_presc_cnt;
  logic                    w_tick;
  logic                    w_presc_wen;
  logic [31:0]             w_presc_rd;
  logic [31:0]             w_presc_new;

  logic [31:0]       w_tcfg [NTIMER];
  logic [31:0]       w_tval [NTIMER];
  logic [NTIMER-1:0] w_pending;

  assign w_tick      = (r_presc_cnt == r_presc);
  assign w_presc_wen = csr_wen && (csr_waddr == PRESC_ADDR);
  assign w_presc_rd  = 32'(r_presc);
  assign w_presc_new = masked_merge(w_presc_rd, csr_wdata, csr_mask);

  generate
    if (PRESCALE_BIT < 32) begin : g_unused_presc
      logic w_unused_presc_bits;
      assign w_unused_presc_bits = ^w_presc_new[31:PRESCALE_BIT];
    end
  endgenerate

  // Rewriting PRESC restarts the tick phase from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc     <= '0;
      r_presc_cnt <= '0;
    end else if (w_presc_wen) begin
      r_presc     <= w_presc_new[PRESCALE_BIT-1:0];
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESCALE_BIT'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NTIMER; gi++) begin : g_chan
      localparam logic [LCSR_BIT-1:0] A_TCFG =
        BASE_ADDR + LCSR_BIT'(LPRESC_STRIDE * gi + LTCFG_OFF);
      localparam logic [LCSR_BIT-1:0] A_TICLR =
        BASE_ADDR + LCSR_BIT'(LPRESC_STRIDE * gi + LTICLR_OFF);

      cpu7_csr_timer_chan #(
        .TIMER_BIT (TIMER_BIT)
      ) u_chan (
        .clk       (clk),
        .resetn    (resetn),
        .tick      (w_tick),
        .cfg_wen   (csr_wen && (csr_waddr == A_TCFG)),
        .ticlr_wen (csr_wen && (csr_waddr == A_TICLR)),
        .wdata     (csr_wdata),
        .mask      (csr_mask),
        .tcfg      (w_tcfg[gi]),
        .tval      (w_tval[gi]),
        .pending   (w_pending[gi])
      );
    end
  endgenerate

  // TICLR and unmapped addresses fall through to zero.
  always_comb begin
    csr_rdata = '0;
    if (csr_raddr == PRESC_ADDR) begin
      csr_rdata = w_presc_rd;
    end
    for (int i = 0; i < NTIMER; i++) begin
      if (csr_raddr == BASE_ADDR + LCSR_BIT'(LPRESC_STRIDE * i + LTCFG_OFF)) begin
        csr_rdata = w_tcfg[i];
      end
      if (csr_raddr == BASE_ADDR + LCSR_BIT'(LPRESC_STRIDE * i + LTVAL_OFF)) begin
        csr_rdata = w_tval[i];
      end
    end
  end

  assign timer_intr     = w_pending;
  assign timer_intr_any = |w_pending;

endmodule

// File: tb/tb_cpu7_csr_timers.sv
// Directed self-checking bench for cpu7_csr_timers (two channels).
module tb_cpu7_csr_timers;

  localparam logic [13:0] A_TCFG0  = 14'h41;
  localparam logic [13:0] A_TVAL0  = 14'h42;
  localparam logic [13:0] A_TICLR0 = 14'h44;
  localparam logic [13:0] A_TCFG1  = 14'h45;
  localparam logic [13:0] A_TVAL1  = 14'h46;
  localparam logic [13:0] A_TICLR1 = 14'h48;
  localparam logic [13:0] A_PRESC  = 14'h49;
  localparam logic [31:0] ALL      = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_mask;
  logic        csr_wen;
  logic [1:0]  timer_intr;
  logic        timer_intr_any;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpu7_csr_timers #(
    .NTIMER       (2),
    .TIMER_BIT    (30),
    .PRESCALE_BIT (8),
    .BASE_ADDR    (14'h41)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_mask       (csr_mask),
    .csr_wen        (csr_wen),
    .timer_intr     (timer_intr),
    .timer_intr_any (timer_intr_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    csr_raddr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic intr_chk(input string tag, input logic [1:0] exp);
    #1;
    chk(tag, {30'b0, timer_intr}, {30'b0, exp});
    chk({tag, "_any"}, {31'b0, timer_intr_any}, {31'b0, |exp});
  endtask

  // Called in the low clock phase; the write lands on the next rising edge.
  task automatic wr(input logic [13:0] addr, input logic [31:0] data, input logic [31:0] mask);
    csr_waddr = addr;
    csr_wdata = data;
    csr_mask  = mask;
    csr_wen   = 1'b1;
    @(negedge clk);
    csr_wen   = 1'b0;
    csr_wdata = '0;
    csr_mask  = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    csr_raddr = '0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_mask  = '0;
    csr_wen   = 1'b0;
    step(3);
    resetn = 1'b1;

    // Reset state
    rd("rst_tcfg0", A_TCFG0, 32'h0);
    rd("rst_tval0", A_TVAL0, 32'h0);
    rd("rst_presc", A_PRESC, 32'h0);
    intr_chk("rst_intr", 2'b00);

    // One-shot ch0, PRESC=0, INITVAL=3
    wr(A_TCFG0, 32'h0000_000D, ALL);
    rd("os_tcfg0", A_TCFG0, 32'h0000_000D);
    rd("os_tval_n1", A_TVAL0, 32'd3);
    step(1); rd("os_tval_n2", A_TVAL0, 32'd2);
    step(1); rd("os_tval_n3", A_TVAL0, 32'd1);
    step(1); rd("os_tval_n4", A_TVAL0, 32'd0);
    intr_chk("os_intr_n4", 2'b00);
    step(1); intr_chk("os_intr_n5", 2'b01);
    rd("os_tval_n5", A_TVAL0, 32'd0);
    step(3); rd("os_tval_hold", A_TVAL0, 32'd0);
    intr_chk("os_intr_hold", 2'b01);
    wr(A_TICLR0, 32'h1, 32'h1);
    intr_chk("os_ticlr", 2'b00);
    rd("os_ticlr_rd", A_TICLR0, 32'h0);
    step(20);
    intr_chk("os_no_repend", 2'b00);
    rd("os_tval_done", A_TVAL0, 32'd0);

    // Periodic ch1, INITVAL=2, PRESC=3; ch0 disabled
    wr(A_TCFG0, 32'h0, ALL);
    wr(A_PRESC, 32'h3, ALL);
    rd("per_presc", A_PRESC, 32'h3);
    wr(A_TCFG1, 32'h0000_000B, ALL);
    rd("per_tcfg1", A_TCFG1, 32'h0000_000B);
    rd("per_tval1", A_TVAL1, 32'd2);
    for (int k = 0; k < 3; k++) begin
      step(10); intr_chk($sformatf("per_quiet_%0d", k), 2'b00);
      step(1);  intr_chk($sformatf("per_pend_%0d", k), 2'b10);
      rd($sformatf("per_reload_%0d", k), A_TVAL1, 32'd2);
      wr(A_TICLR1, 32'h1, 32'h1);
      intr_chk($sformatf("per_clr_%0d", k), 2'b00);
    end

    // Masked TCFG write reloads INITVAL
    wr(A_TCFG1, 32'h0, ALL);
    wr(A_PRESC, 32'h0, ALL);
    wr(A_TCFG0, 32'h0000_0015, ALL);
    step(2); rd("mask_tval_pre", A_TVAL0, 32'd3);
    wr(A_TCFG0, 32'h1, 32'h3);
    rd("mask_tcfg0", A_TCFG0, 32'h0000_0015);
    rd("mask_tval_reload", A_TVAL0, 32'd5);

    // PRESC rewrite mid-count restarts the tick phase
    wr(A_PRESC, 32'h3, ALL);
    wr(A_TCFG0, 32'h0000_0015, ALL);
    step(5); rd("phase_tval_a", A_TVAL0, 32'd4);
    wr(A_PRESC, 32'h3, ALL);
    step(3); rd("phase_tval_b", A_TVAL0, 32'd4);
    step(1); rd("phase_tval_c", A_TVAL0, 32'd3);

    // TICLR on the expiry cycle: set wins
    wr(A_TCFG0, 32'h0, ALL);
    wr(A_TICLR0, 32'h1, 32'h1);
    wr(A_PRESC, 32'h0, ALL);
    intr_chk("col_pre", 2'b00);
    wr(A_TCFG0, 32'h0000_0005, ALL);
    rd("col_tval_1", A_TVAL0, 32'd1);
    step(1); rd("col_tval_0", A_TVAL0, 32'd0);
    intr_chk("col_before", 2'b00);
    wr(A_TICLR0, 32'h1, 32'h1);
    intr_chk("col_set_wins", 2'b01);
    wr(A_TICLR0, 32'h1, 32'h1);
    intr_chk("col_cleared", 2'b00);
    step(4); intr_chk("col_done", 2'b00);

    // TCFG write on a tick cycle, and ignored TVAL write
    wr(A_TCFG0, 32'h0000_0021, ALL);
    rd("tick_tval_8", A_TVAL0, 32'd8);
    step(1); rd("tick_tval_7", A_TVAL0, 32'd7);
    wr(A_TCFG0, 32'h0000_0019, ALL);
    rd("tick_cfg_wins", A_TVAL0, 32'd6);
    wr(A_TVAL0, 32'h0000_03FF, ALL);
    rd("tval_wr_ignored", A_TVAL0, 32'd5);

    // Asynchronous reset mid-count
    wr(A_TCFG1, 32'h0000_0003, ALL);
    step(1); intr_chk("ar_pre_intr", 2'b10);
    rd("ar_pre_tval0", A_TVAL0, 32'd3);
    resetn = 1'b0;
    intr_chk("ar_async_intr", 2'b00);
    rd("ar_async_tval0", A_TVAL0, 32'd0);
    rd("ar_async_tcfg1", A_TCFG1, 32'd0);
    step(1);
    resetn = 1'b1;
    step(5);
    rd("ar_tval0_stay", A_TVAL0, 32'd0);
    rd("ar_tcfg0", A_TCFG0, 32'd0);
    intr_chk("ar_intr_stay", 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu7_csr_timers.md
# cpu7_csr_timers

Parametrised multi-channel timer CSR unit: the next generation of the CSR timer. It provides NTIMER independent countdown timers, each with its own TCFG, TVAL and TICLR registers, plus one shared prescaler. It sits beside the CSR file on the same CSR read/write port and drives per-channel interrupt pending bits into ESTAT.IS and the ecl interrupt logic.

## Interface
- NTIMER, 2: number of timer channels, 1..8.
- TIMER_BIT, 30: counter/initval width, ≤30.
- PRESCALE_BIT, 8: prescaler width.
- BASE_ADDR, 14'h41: CSR address of channel 0 TCFG.
- Channel i registers: TCFG at BASE_ADDR+4i, TVAL at BASE_ADDR+4i+1, TICLR at BASE_ADDR+4i+3.
- Shared PRESC register at BASE_ADDR+4·NTIMER.
- clk  in  1  core clock.
- resetn  in  1  reset; asynchronous, active-low. One clock domain.
- csr_raddr  in  LCSR_BIT  read address.
- csr_rdata  out  32  read data, combinational; 0 for unmapped addresses.
- csr_waddr  in  LCSR_BIT  write address.
- csr_wdata  in  32  write data.
- csr_mask  in  32  per-bit write mask.
- csr_wen  in  1  write strobe, one cycle per write.
- timer_intr  out  NTIMER  per-channel pending bit (registered).
- timer_intr_any  out  1  OR of timer_intr.

## Operation
- TCFG fields: bit0 EN, bit1 PERIODIC, [TIMER_BIT+1:2] INITVAL. Masked merge: new = (old & ~mask) | (wdata & mask).
- Any TCFG write (any mask) loads the counter with the merged INITVAL, clears the channel's done flag and resets nothing else.
- PRESC[PRESCALE_BIT-1:0]: a tick fires when presc_cnt == PRESC; presc_cnt then wraps to 0, otherwise it increments. A PRESC write clears presc_cnt. PRESC=0 gives a tick every cycle. All channels share the tick.
- Channel behaviour on a tick, with EN=1 and done=0:
  - count≠0: count−1.
  - count==0: set pending. If PERIODIC, count ← INITVAL. If not, done ← 1, count holds at 0, and the channel produces no further pending until the next TCFG write.
- EN=0: count frozen, presc_cnt keeps running.
- TICLR: a write with wdata[0]&mask[0] clears pending. It reads as 0.
- A set and clear in the same cycle: set wins.
- TVAL reads {0, count}. TVAL writes are ignored.
- TCFG reads {0, INITVAL, PERIODIC, EN}. PRESC reads zero-extended.
- A TCFG write on the same cycle as a tick: the write wins. The count loads INITVAL and the tick is ignored for that channel.
- Reset values: all TCFG fields 0, count 0, PRESC 0, presc_cnt 0, pending 0, done 0, so timer_intr=0 and timer_intr_any=0.
- Reset asserted mid-count: everything returns to the reset values immediately (asynchronous).

## Timing
- Write in cycle N is visible on csr_rdata at N+1. Read data is same-cycle combinational.
- Example with PRESC=0: write TCFG {INITVAL=3, EN=1} at N.
  - TVAL reads 3 at N+1, 2 at N+2, 1 at N+3, 0 at N+4.
  - timer_intr[i] rises at N+5.
  - If periodic, TVAL=3 again at N+5.
- Period is (INITVAL+1)·(PRESC+1) cycles. INITVAL=0 with PERIODIC pends on every tick.
- TICLR write at M clears timer_intr at M+1 unless a new expiry also lands at M.

## Structure
- Field bit positions, register offsets and BASE_ADDR default go into csr_defs.v as `LTCFG_*/`LTICLR_*/`LPRESC_*.
- Sub-module cpu7_csr_timer_chan holds one channel: TCFG fields, counter, done and pending.
  - Inputs: clk, resetn, tick, cfg_wen, ticlr_wen, wdata, mask.
  - Outputs: tcfg, tval, pending.
- The top generates NTIMER instances. It also holds the prescaler, the address decode and the read mux.
- Flops use dffrle_ns/dffre_ns.

## Test plan
- Reset: after resetn deasserts, reading TCFG0, TVAL0 and PRESC gives 0, and timer_intr=0.
- One-shot ch0, PRESC=0, INITVAL=3: timer_intr[0] rises exactly 5 cycles after the write. TVAL then stays 0 and no re-pend happens after a TICLR clear.
- Periodic ch1, INITVAL=2, PRESC=3: pend every 12 cycles. Clear each pend via TICLR. Channel 0, left disabled, never pends.
- Masked TCFG write with mask=0x3 over INITVAL=5: INITVAL is kept and count reloads to 5. PRESC write mid-count restarts the tick phase.
- Collisions:
  - TICLR clear on the expiry cycle: timer_intr stays 1.
  - TCFG write on a tick cycle: count = new INITVAL.
- resetn asserted mid-count for one cycle: all outputs are 0 asynchronously and the counter does not resume.
